pipelined_cla_addsub: RTL and testbench
=======================================

Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the calculator datapath.
- Operands are split into GROUP-bit lookahead groups.
- One group is resolved per pipeline stage, and the carry between groups is registered.
- A valid/ready handshake on both sides allows back-to-back operations and downstream stalls.
- Sits between the operand registers and the result/flag register that feeds the display logic. It replaces the fixed 4-bit combinational lookahead adder in the add/subtract path.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of GROUP and at least GROUP.
GROUP, 4, lookahead group width; one group is resolved per pipeline stage.
(Derived) STAGES = WIDTH/GROUP, pipeline depth and latency in cycles.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
a  in  WIDTH  operand A, two's complement or unsigned.
b  in  WIDTH  operand B.
sub  in  1  0 = A+B, 1 = A-B.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts the result.
s  out  WIDTH  sum or difference.
cout  out  1  carry out of the MSB; for subtraction, 1 = no borrow (A >= B unsigned).
ovr  out  1  signed overflow.
zero  out  1  s == 0.
neg  out  1  s[WIDTH-1].

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst asserted forces all stage valid bits, s, cout, ovr, zero, neg, and internal carries to 0 immediately, independent of clk.
  - in_ready reads 1 while rst is high and after release.
- Operation:
  - b_eff = sub ? ~b : b; carry-in = sub.
  - Inside each group: P = a^b_eff, G = a&b_eff, and the carries follow the lookahead recurrence.
  - Group P/G (Pout = AND of all P; Gout = the standard lookahead expression) are computed per group and used for the inter-group carry.
- Pipeline:
  - Stage k (k = 0..STAGES-1) resolves group k using the carry registered by stage k-1; stage 0 uses carry-in.
  - Operand bits of groups not yet resolved, and sum bits already resolved, travel with the beat in skew registers.
  - Each stage holds a valid bit.
- Latency:
  - A beat accepted on cycle t appears on out_valid at t+STAGES when there is no stall.
  - Throughput is 1 beat/cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - A beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
  - When advance = 0, every stage holds (global stall): s, cout, ovr, zero, neg and out_valid stay stable, and the inputs are ignored.
  - When advance = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
  - Accept and consume in the same cycle are legal and keep the pipeline full.
- Flags, registered with the final stage:
  - cout = C[WIDTH].
  - ovr = C[WIDTH] ^ C[WIDTH-1].
  - zero = (s == 0).
  - neg = s[WIDTH-1].
  - Flags are meaningful only while out_valid = 1. Otherwise they retain their last values; after reset they are 0.
- Width rules:
  - No sign extension.
  - The result wraps modulo 2^WIDTH.
  - sub with b = 0 yields s = a and cout = 1.
- Reset mid-operation: all in-flight beats are discarded, and out_valid drops within the same cycle that rst rises.
- in_valid held high with no acceptance: no requirement that the same data is re-presented. Only accepted beats are processed.

Test Plan:
- WIDTH=8, GROUP=4: a=0x7F, b=0x01, sub=0, out_ready=1 -> out_valid 2 cycles after accept; s=0x80, cout=0, ovr=1, neg=1, zero=0.
- a=0xFF, b=0x01, sub=0 -> s=0x00, cout=1, ovr=0, zero=1; then a=0x05, b=0x07, sub=1 on the next cycle -> s=0xFE, cout=0, ovr=0, neg=1, one cycle after the first result.
- a=0x80, b=0x01, sub=1 -> s=0x7F, cout=1, ovr=1, neg=0; a=0x80, b=0x80, sub=0 -> s=0x00, cout=1, ovr=1, zero=1.
- Stream of 6 beats (a=i, b=0x10, sub=0) with out_ready held 0 for 3 cycles after the first result -> in_ready=0 during the stall; the output holds s=0x10; all 6 results 0x10..0x15 arrive in order with no loss or duplication.
- Two beats in flight, rst pulsed for 1 cycle asynchronously -> out_valid, s and flags become 0 immediately; no stale result ever appears; the next beat after release (0x03+0x04) gives s=0x07 after 2 cycles.
- WIDTH=16, GROUP=4 -> latency 4; 0x7FFF+0x0001 gives s=0x8000, ovr=1; 0x1234-0x1234 gives s=0, zero=1, cout=1.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one GROUP-bit
// lookahead group, and the inter-group carry is registered between stages.
module pipelined_cla_addsub #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovr,
  output logic             zero,
  output logic             neg
);
  localparam int STAGES = WIDTH / GROUP;

  logic advance;

  // Lookahead carry into bit n of a group: G[n-1] | P[n-1]G[n-2] | ... | P[n-1:0]cin.
  function automatic logic carry_into(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g,
                                      input logic cin, input int n);
    logic acc;
    logic pp;
    acc = 1'b0;
    pp  = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc = acc | (pp & g[j]);
      pp  = pp & p[j];
    end
    return acc | (pp & cin);
  endfunction

  // A beat entering stage k is packed as {b_eff unresolved, a unresolved, sum resolved}.
  // Resolving a group swaps its a bits for sum bits and drops its b bits, so the beat
  // shrinks by GROUP bits per stage and is exactly the result after the last stage.
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = 2 * WIDTH - k * GROUP;
    localparam int OW = IW - GROUP;
    localparam int LO = k * GROUP;

    logic [IW-1:0]    beat_in;
    logic             v_in;
    logic             c_in;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] c;
    logic [GROUP-1:0] grp_sum;
    logic             pout;
    logic             gout;
    logic             c_out;
    logic [OW-1:0]    nxt;
    logic             valid_q;
    logic             carry_q;
    logic [OW-1:0]    beat_q;

    if (k == 0) begin : g_src
      assign beat_in = {b ^ {WIDTH{sub}}, a};
      assign v_in    = in_valid;
      assign c_in    = sub;
    end else begin : g_src
      assign beat_in = g_stage[k-1].beat_q;
      assign v_in    = g_stage[k-1].valid_q;
      assign c_in    = g_stage[k-1].carry_q;
    end

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
      p = beat_in[LO +: GROUP] ^ beat_in[WIDTH +: GROUP];
      g = beat_in[LO +: GROUP] & beat_in[WIDTH +: GROUP];
      c = '0;
      for (int i = 0; i < GROUP; i++) c[i] = carry_into(p, g, c_in, i);
      grp_sum = p ^ c;
      pout    = &p;
      gout    = carry_into(p, g, 1'b0, GROUP);
      c_out   = gout | (pout & c_in);
      nxt     = '0;
      for (int i = 0; i < WIDTH; i++)
        nxt[i] = (i >= LO && i < LO + GROUP) ? grp_sum[i-LO] : beat_in[i];
      for (int i = WIDTH; i < OW; i++) nxt[i] = beat_in[i+GROUP];
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge;
    // the asynchronous reset clears valids, carries and data without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        beat_q  <= '0;
      end else if (advance) begin
        valid_q <= v_in;
        if (v_in) begin
          beat_q  <= nxt;
          carry_q <= c_out;
        end
      end
    end

    if (k == STAGES - 1) begin : g_flags
      logic ovr_q;
      logic zero_q;
      logic neg_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovr_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (advance && v_in) begin
          ovr_q  <= c_out ^ c[GROUP-1];
          zero_q <= (nxt == '0);
          neg_q  <= nxt[OW-1];
        end
      end
    end
  end

  // One global stall: the whole pipeline moves only when the output slot can drain.
  assign out_valid = g_stage[STAGES-1].valid_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign s         = g_stage[STAGES-1].beat_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovr       = g_stage[STAGES-1].g_flags.ovr_q;
  assign zero      = g_stage[STAGES-1].g_flags.zero_q;
  assign neg       = g_stage[STAGES-1].g_flags.neg_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub: 8-bit (2-stage) and 16-bit (4-stage) instances,
// hand-computed results, stall/stream ordering and asynchronous reset mid-flight.
module tb_pipelined_cla_addsub;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8;
  logic        cout8, ovr8, zero8, neg8;
  logic [7:0]  a8, b8, s8;
  logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16;
  logic        cout16, ovr16, zero16, neg16;
  logic [15:0] a16, b16, s16;

  int checks = 0;
  int errors = 0;

  pipelined_cla_addsub #(.WIDTH(8), .GROUP(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .s(s8), .cout(cout8),
    .ovr(ovr8), .zero(zero8), .neg(neg8)
  );

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16), .s(s16), .cout(cout16),
    .ovr(ovr16), .zero(zero16), .neg(neg16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic ss);
    in_valid8 = v;
    a8        = aa;
    b8        = bb;
    sub8      = ss;
  endtask

  task automatic expect8(input string tag, input logic [7:0] es, input logic ec,
                         input logic eo, input logic ez, input logic en);
    check({tag, ".out_valid"}, 32'(out_valid8), 32'd1);
    check({tag, ".s"},         32'(s8),         32'(es));
    check({tag, ".cout"},      32'(cout8),      32'(ec));
    check({tag, ".ovr"},       32'(ovr8),       32'(eo));
    check({tag, ".zero"},      32'(zero8),      32'(ez));
    check({tag, ".neg"},       32'(neg8),       32'(en));
  endtask

  task automatic expect16(input string tag, input logic [15:0] es, input logic ec,
                          input logic eo, input logic ez, input logic en);
    check({tag, ".out_valid"}, 32'(out_valid16), 32'd1);
    check({tag, ".s"},         32'(s16),         32'(es));
    check({tag, ".cout"},      32'(cout16),      32'(ec));
    check({tag, ".ovr"},       32'(ovr16),       32'(eo));
    check({tag, ".zero"},      32'(zero16),      32'(ez));
    check({tag, ".neg"},       32'(neg16),       32'(en));
  endtask

  initial begin
    int sent;
    int got;
    int stalls;

    rst = 1'b1;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    out_ready8  = 1'b1;
    in_valid16  = 1'b0;
    a16         = 16'h0000;
    b16         = 16'h0000;
    sub16       = 1'b0;
    out_ready16 = 1'b1;
    #1;
    check("rst.in_ready", 32'(in_ready8), 32'd1);
    check("rst.out_valid", 32'(out_valid8), 32'd0);
    check("rst.s", 32'(s8), 32'd0);
    check("rst.flags", {28'd0, cout8, ovr8, zero8, neg8}, 32'd0);
    check("rst.out_valid16", 32'(out_valid16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 0x7F + 0x01: signed overflow into the sign bit, latency 2
    drive8(1'b1, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    check("t1.early", 32'(out_valid8), 32'd0);
    @(negedge clk);
    expect8("t1", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

    // back-to-back: 0xFF + 0x01 then 0x05 - 0x07
    drive8(1'b1, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    drive8(1'b1, 8'h05, 8'h07, 1'b1);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    expect8("t2a", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expect8("t2b", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);

    // 0x80 - 0x01, 0x80 + 0x80, 0x5A - 0x00 streamed
    drive8(1'b1, 8'h80, 8'h01, 1'b1);
    @(negedge clk);
    drive8(1'b1, 8'h80, 8'h80, 1'b0);
    @(negedge clk);
    drive8(1'b1, 8'h5A, 8'h00, 1'b1);
    expect8("t3a", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    expect8("t3b", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    expect8("t3c", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3.bubble", 32'(out_valid8), 32'd0);

    // six beats a=i, b=0x10 with a 3-cycle downstream stall on the first result
    sent   = 0;
    got    = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      #1;
      out_ready8 = !(out_valid8 && stalls < 3);
      drive8(sent < 6, 8'(sent), 8'h10, 1'b0);
      #1;
      if (!out_ready8) begin
        stalls++;
        check("stall.in_ready", 32'(in_ready8), 32'd0);
        check("stall.s", 32'(s8), 32'h10);
      end
      if (out_valid8 && out_ready8) begin
        check("stream.s", 32'(s8), 32'((got + 16) & 255));
        got++;
      end
      if (in_valid8 && in_ready8) sent++;
    end
    check("stream.count", 32'(got), 32'd6);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    out_ready8 = 1'b1;
    @(negedge clk);
    check("stream.drained", 32'(out_valid8), 32'd0);

    // asynchronous reset with two beats in flight
    drive8(1'b1, 8'hF0, 8'h20, 1'b0);
    @(negedge clk);
    drive8(1'b1, 8'h7F, 8'h7F, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    expect8("t5.pre", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5.out_valid", 32'(out_valid8), 32'd0);
    check("t5.s", 32'(s8), 32'd0);
    check("t5.flags", {28'd0, cout8, ovr8, zero8, neg8}, 32'd0);
    check("t5.in_ready", 32'(in_ready8), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5.no_stale", 32'(out_valid8), 32'd0);
    end
    drive8(1'b1, 8'h03, 8'h04, 1'b0);
    @(negedge clk);
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    check("t5.early", 32'(out_valid8), 32'd0);
    @(negedge clk);
    expect8("t5.post", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);

    // 16-bit instance: latency 4
    in_valid16 = 1'b1;
    a16 = 16'h7FFF;
    b16 = 16'h0001;
    sub16 = 1'b0;
    @(negedge clk);
    a16 = 16'h1234;
    b16 = 16'h1234;
    sub16 = 1'b1;
    check("t6.lat1", 32'(out_valid16), 32'd0);
    @(negedge clk);
    in_valid16 = 1'b0;
    check("t6.lat2", 32'(out_valid16), 32'd0);
    @(negedge clk);
    check("t6.lat3", 32'(out_valid16), 32'd0);
    @(negedge clk);
    expect16("t6a", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expect16("t6b", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
